pc_gen_btb: RTL and testbench

- Parametrised successor to the single-issue next-PC register.
- Owns the fetch PC, selects the next PC from pipeline redirects, and adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for taken-branch prediction.
- Latches redirects that arrive during a stall so they are not lost.
- Sits at the head of IF; feeds the I-memory address and the IF/ID prediction tag.

---
 rtl/pc_gen_pkg.sv | 41 ++++
 rtl/btb_dm.sv | 78 +++++++
 rtl/pc_gen_btb.sv | 111 +++++++++++
 tb/tb_pc_gen_btb.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_pkg
// Description : Shared definitions for the fetch PC generator and its BTB:
//               2-bit counter encodings, the PC increment, the BTB entry
//               record and the saturating counter update helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

   localparam logic [1:0] STRONG_NT = 2'b00;
   localparam logic [1:0] WEAK_NT   = 2'b01;
   localparam logic [1:0] WEAK_T    = 2'b10;
   localparam logic [1:0] STRONG_T  = 2'b11;

   localparam int unsigned PC_INC = 4;

   // Widest supported PC; entries are sized to it and narrower
   // configurations zero-extend into the upper bits.
   localparam int unsigned PC_W_MAX = 64;

   typedef struct packed {
      logic                valid;
      logic [PC_W_MAX-1:0] tag;
      logic [PC_W_MAX-1:0] target;
      logic [1:0]          ctr;
   } btb_entry_t;

   // Saturating +/-1 on a 2-bit counter.
   function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
      logic [1:0] r;
      r = ctr;
      if (taken && (ctr != STRONG_T))
         r = ctr + 2'd1;
      else if (!taken && (ctr != STRONG_NT))
         r = ctr - 2'd1;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btb_dm.sv
`default_nettype none
// ============================================================================
// Module      : btb_dm
// Description : Direct-mapped branch target buffer with 2-bit counters.
//               Combinational lookup, synchronous update, read-before-write.
// Ports       : clk, rst            - clock, sync active-high reset
//               lookup_pc           - PC to predict for
//               pred_taken/target   - hit & ctr[1], stored target (0 if not)
//               upd_valid/pc/target/taken - resolved-branch update
// Revision    : 1.0 - initial release
// ============================================================================
module btb_dm
   import pc_gen_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_taken
);

   localparam int unsigned IDX   = $clog2(ENTRIES);
   localparam int unsigned TAG_W = XLEN - IDX - 2;

   btb_entry_t r_mem [ENTRIES];

   logic [IDX-1:0]      w_lk_idx;
   logic [IDX-1:0]      w_up_idx;
   logic [PC_W_MAX-1:0] w_lk_tag;
   logic [PC_W_MAX-1:0] w_up_tag;
   logic [PC_W_MAX-1:0] w_up_tgt;
   btb_entry_t          w_lk_ent;
   btb_entry_t          w_up_ent;
   logic                w_lk_hit;
   logic                w_up_hit;

   always_comb begin
      w_lk_idx = lookup_pc[IDX+1:2];
      w_up_idx = upd_pc[IDX+1:2];
      w_lk_tag = '0;
      w_up_tag = '0;
      w_up_tgt = '0;
      w_lk_tag[TAG_W-1:0] = lookup_pc[XLEN-1:IDX+2];
      w_up_tag[TAG_W-1:0] = upd_pc[XLEN-1:IDX+2];
      w_up_tgt[XLEN-1:0]  = upd_target;
      w_lk_ent = r_mem[w_lk_idx];
      w_up_ent = r_mem[w_up_idx];
      w_lk_hit = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag);
      w_up_hit = w_up_ent.valid && (w_up_ent.tag == w_up_tag);
      pred_taken  = w_lk_hit && w_lk_ent.ctr[1];
      pred_target = pred_taken ? w_lk_ent.target[XLEN-1:0] : '0;
   end

   // Only valid bits are reset; tag/target/ctr are qualified by valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(ENTRIES); i++)
            r_mem[i].valid <= 1'b0;
      end else if (upd_valid) begin
         if (w_up_hit) begin
            r_mem[w_up_idx].ctr <= ctr_step(w_up_ent.ctr, upd_taken);
            if (upd_taken)
               r_mem[w_up_idx].target <= w_up_tgt;
         end else if (upd_taken) begin
            r_mem[w_up_idx] <= '{valid: 1'b1, tag: w_up_tag, target: w_up_tgt, ctr: WEAK_T};
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pc_gen_btb.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_btb
// Description : Fetch PC register with redirect priority mux, a pending
//               register that holds EX redirects seen during a stall, and a
//               direct-mapped BTB for taken-branch prediction.
//               Optional macro PC_GEN_TRAP_EN adds trap_valid/trap_vector,
//               which override everything including a stall.
// Ports       : clk, rst, en (0 = stall)
//               ex_redirect/ex_target, id_jal/id_jal_target - redirects
//               upd_*            - BTB update from resolved branch
//               pc_out           - registered fetch PC
//               pred_taken/target - combinational BTB prediction for pc_out
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen_btb
   import pc_gen_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter int unsigned     BTB_ENTRIES  = 16,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
`ifdef PC_GEN_TRAP_EN
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vector,
`endif
   input  logic            ex_redirect,
   input  logic [XLEN-1:0] ex_target,
   input  logic            id_jal,
   input  logic [XLEN-1:0] id_jal_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_taken,
   output logic [XLEN-1:0] pc_out,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target
);

   logic [XLEN-1:0] r_pc;
   logic            r_pend_valid;
   logic [XLEN-1:0] r_pend_target;

   logic [XLEN-1:0] w_pc_next;
   logic            w_pend_valid_next;
   logic [XLEN-1:0] w_pend_target_next;

   btb_dm #(
      .XLEN    (XLEN),
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk         (clk),
      .rst         (rst),
      .lookup_pc   (r_pc),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_target  (upd_target),
      .upd_taken   (upd_taken)
   );

   always_comb begin
      w_pc_next          = r_pc;
      w_pend_valid_next  = r_pend_valid;
      w_pend_target_next = r_pend_target;
      if (en) begin
         // A pending redirect is older than any live one, so it wins.
         if (r_pend_valid) begin
            w_pc_next         = r_pend_target;
            w_pend_valid_next = 1'b0;
         end else if (ex_redirect)
            w_pc_next = ex_target;
         else if (id_jal)
            w_pc_next = id_jal_target;
         else if (pred_taken)
            w_pc_next = pred_target;
         else
            w_pc_next = r_pc + XLEN'(PC_INC);
      end else if (ex_redirect) begin
         // Newest EX redirect during a stall overwrites any earlier one.
         w_pend_valid_next  = 1'b1;
         w_pend_target_next = ex_target;
      end
`ifdef PC_GEN_TRAP_EN
      if (trap_valid) begin
         w_pc_next         = trap_vector;
         w_pend_valid_next = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_VECTOR;
         r_pend_valid  <= 1'b0;
         r_pend_target <= '0;
      end else begin
         r_pc          <= w_pc_next;
         r_pend_valid  <= w_pend_valid_next;
         r_pend_target <= w_pend_target_next;
      end
   end

   assign pc_out = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_btb.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen_btb
// Description : Scoreboard bench for pc_gen_btb (BTB_ENTRIES=4,
//               RESET_VECTOR=0x100). The driver pushes the outputs expected
//               in each cycle; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen_btb;

   typedef struct {
      logic [31:0] pc;
      logic        pt;
      logic [31:0] tgt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_vector = '0;
   logic        ex_redirect = 1'b0;
   logic [31:0] ex_target = '0;
   logic        id_jal = 1'b0;
   logic [31:0] id_jal_target = '0;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic [31:0] upd_target = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] pc_out;
   logic        pred_taken;
   logic [31:0] pred_target;

   int   checks = 0;
   int   failures = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   pc_gen_btb #(
      .XLEN         (32),
      .BTB_ENTRIES  (4),
      .RESET_VECTOR (32'h100)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
`ifdef PC_GEN_TRAP_EN
      .trap_valid    (trap_valid),
      .trap_vector   (trap_vector),
`endif
      .ex_redirect   (ex_redirect),
      .ex_target     (ex_target),
      .id_jal        (id_jal),
      .id_jal_target (id_jal_target),
      .upd_valid     (upd_valid),
      .upd_pc        (upd_pc),
      .upd_target    (upd_target),
      .upd_taken     (upd_taken),
      .pc_out        (pc_out),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target)
   );

   // Monitor: one expected record per cycle.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (pc_out !== e.pc) begin
            failures++;
            $display("FAIL pc_out: got %h expected %h", pc_out, e.pc);
         end
         checks++;
         if (pred_taken !== e.pt) begin
            failures++;
            $display("FAIL pred_taken @pc %h: got %b expected %b", e.pc, pred_taken, e.pt);
         end
         checks++;
         if (pred_target !== e.tgt) begin
            failures++;
            $display("FAIL pred_target @pc %h: got %h expected %h", e.pc, pred_target, e.tgt);
         end
      end
   end

   // Push this cycle's expectation, advance one clock, clear one-shot inputs.
   task automatic cyc(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
      exp_t e;
      e.pc = pc; e.pt = pt; e.tgt = tgt;
      q.push_back(e);
      @(posedge clk);
      #1;
      ex_redirect = 1'b0;
      id_jal      = 1'b0;
      upd_valid   = 1'b0;
      trap_valid  = 1'b0;
   endtask

   task automatic redir(input logic [31:0] t);
      ex_redirect = 1'b1; ex_target = t;
   endtask

   task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
      upd_valid = 1'b1; upd_pc = p; upd_target = t; upd_taken = tk;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      @(posedge clk); #1;
      cyc(32'h100, 1'b0, 32'h0);                 // reset state
      rst = 1'b0;
      cyc(32'h100, 1'b0, 32'h0);
      cyc(32'h104, 1'b0, 32'h0);
      cyc(32'h108, 1'b0, 32'h0);
      // stall with two captured redirects, newest wins
      en = 1'b0; redir(32'h200); cyc(32'h10C, 1'b0, 32'h0);
      en = 1'b0; redir(32'h300); cyc(32'h10C, 1'b0, 32'h0);
      en = 1'b1;                 cyc(32'h10C, 1'b0, 32'h0);
      cyc(32'h300, 1'b0, 32'h0);
      // ex_redirect beats id_jal
      redir(32'h400); id_jal = 1'b1; id_jal_target = 32'h500;
      cyc(32'h304, 1'b0, 32'h0);
      // install 0x404 -> 0x600, then id_jal beats the BTB hit
      upd(32'h404, 32'h600, 1'b1); cyc(32'h400, 1'b0, 32'h0);
      id_jal = 1'b1; id_jal_target = 32'h500;
      cyc(32'h404, 1'b1, 32'h600);
      // 0x40 -> 0x80 taken, predicted, then trained down to 00
      upd(32'h40, 32'h80, 1'b1); cyc(32'h500, 1'b0, 32'h0);
      redir(32'h40);             cyc(32'h504, 1'b0, 32'h0);
      cyc(32'h40, 1'b1, 32'h80);
      upd(32'h40, 32'h80, 1'b0); cyc(32'h80, 1'b0, 32'h0);
      upd(32'h40, 32'h80, 1'b0); cyc(32'h84, 1'b0, 32'h0);
      redir(32'h40);             cyc(32'h88, 1'b0, 32'h0);
      cyc(32'h40, 1'b0, 32'h0);
      // train back up to 10, then alias 0x50 must miss
      upd(32'h40, 32'h80, 1'b1); cyc(32'h44, 1'b0, 32'h0);
      upd(32'h40, 32'h80, 1'b1); redir(32'h50); cyc(32'h48, 1'b0, 32'h0);
      cyc(32'h50, 1'b0, 32'h0);
      redir(32'h40);             cyc(32'h54, 1'b0, 32'h0);
      cyc(32'h40, 1'b1, 32'h80);
      // allocate 0x80 while fetching it: read-before-write
      upd(32'h80, 32'hC0, 1'b1); cyc(32'h80, 1'b0, 32'h0);
      redir(32'h80);             cyc(32'h84, 1'b0, 32'h0);
      cyc(32'h80, 1'b1, 32'hC0);
      // PC wraparound
      redir(32'hFFFF_FFFC);      cyc(32'hC0, 1'b0, 32'h0);
      cyc(32'hFFFF_FFFC, 1'b0, 32'h0);
      cyc(32'h0, 1'b0, 32'h0);
      // reset mid-stall drops the pending redirect and BTB contents
      en = 1'b0; redir(32'h200); cyc(32'h4, 1'b0, 32'h0);
      rst = 1'b1; en = 1'b0;     cyc(32'h4, 1'b0, 32'h0);
      rst = 1'b0; en = 1'b1;     cyc(32'h100, 1'b0, 32'h0);
      redir(32'h80);             cyc(32'h104, 1'b0, 32'h0);
      cyc(32'h80, 1'b0, 32'h0);
`ifdef PC_GEN_TRAP_EN
      // trap during stall overrides and drops pending 0x200
      en = 1'b0; redir(32'h200); cyc(32'h84, 1'b0, 32'h0);
      en = 1'b0; trap_valid = 1'b1; trap_vector = 32'h700;
      cyc(32'h84, 1'b0, 32'h0);
      en = 1'b1;                 cyc(32'h700, 1'b0, 32'h0);
      cyc(32'h704, 1'b0, 32'h0);
`endif
      @(negedge clk); #1;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
